fifo_read_checker: RTL



---
 rtl/fifo_chk_pkg.sv | 23 ++
 rtl/fifo_read_checker.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_chk_pkg.sv
// Shared types and helpers for the FIFO read-side traffic checker.
package fifo_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned SAT_W      = 64;

  // Increment that sticks at the all-ones value of a width-bit counter (width 1..SAT_W).
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input int unsigned      width);
    logic [SAT_W-1:0] max_val;
    max_val = {SAT_W{1'b1}} >> (SAT_W - width);
    return (val >= max_val) ? val : val + SAT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_read_checker.sv
// Drains a FIFO read port and checks each word against an incrementing pattern,
// reporting pass/fail, error count, first mismatch and an idle timeout.
module fifo_read_checker
  import fifo_chk_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned CNT_LEN  = 16,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [CNT_LEN-1:0]  num_words_i,
  input  logic [DATA_LEN-1:0] seed_i,
  input  logic                hold_i,
  input  logic                rempty_i,
  input  logic [DATA_LEN-1:0] rdata_i,
  output logic                read_en_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic                timeout_o,
  output logic [CNT_LEN-1:0]  err_cnt_o,
  output logic [CNT_LEN-1:0]  first_err_idx_o,
  output logic [DATA_LEN-1:0] first_err_data_o
);

  localparam int unsigned TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
    $error("fifo_read_checker: RD_LAT out of range");
  end

  chk_state_e          state_q, state_d;
  logic [CNT_LEN-1:0]  nw_q, nw_d;
  logic [DATA_LEN-1:0] seed_q, seed_d;
  logic [CNT_LEN-1:0]  issued_q, issued_d;
  logic [CNT_LEN-1:0]  checked_q, checked_d;
  logic [RD_LAT-1:0]   vpipe_q, vpipe_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [CNT_LEN-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_LEN-1:0]  ferr_idx_q, ferr_idx_d;
  logic [DATA_LEN-1:0] ferr_data_q, ferr_data_d;

  logic                rd_en_c;
  logic                active_c;
  logic                cmp_v_c;
  logic [DATA_LEN-1:0] exp_data_c;
  logic [RD_LAT:0]     pipe_ext_c;

  // Next-state, counters and result tracking.
  always_comb begin
    state_d     = state_q;
    nw_d        = nw_q;
    seed_d      = seed_q;
    issued_d    = issued_q;
    checked_d   = checked_q;
    tmo_cnt_d   = tmo_cnt_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_cnt_d   = err_cnt_q;
    ferr_idx_d  = ferr_idx_q;
    ferr_data_d = ferr_data_q;

    active_c   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    rd_en_c    = (state_q == ST_RUN) && !rempty_i && !hold_i && (issued_q < nw_q);
    cmp_v_c    = active_c && vpipe_q[RD_LAT-1];
    exp_data_c = seed_q + DATA_LEN'(checked_q);
    pipe_ext_c = {vpipe_q, rd_en_c};
    vpipe_d    = pipe_ext_c[RD_LAT-1:0];

    if (rd_en_c) issued_d = issued_q + CNT_LEN'(1);

    if (cmp_v_c) begin
      checked_d = checked_q + CNT_LEN'(1);
      tmo_cnt_d = '0;
      if (rdata_i != exp_data_c) begin
        err_cnt_d = CNT_LEN'(sat_inc(SAT_W'(err_cnt_q), CNT_LEN));
        if (err_cnt_q == '0) begin
          ferr_idx_d  = checked_q;
          ferr_data_d = rdata_i;
        end
      end
    end else if (active_c && (TIMEOUT != 0)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          nw_d        = num_words_i;
          seed_d      = seed_i;
          issued_d    = '0;
          checked_d   = '0;
          tmo_cnt_d   = '0;
          vpipe_d     = '0;
          err_cnt_d   = '0;
          ferr_idx_d  = '0;
          ferr_data_d = '0;
          timeout_d   = 1'b0;
          // An empty run completes immediately with nothing to check.
          if (num_words_i == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (issued_d == nw_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (checked_d == nw_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0) && !timeout_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle timeout aborts the run and throws away anything still in flight.
    if (active_c && (TIMEOUT != 0) && (tmo_cnt_d == TMO_W'(TIMEOUT))) begin
      state_d   = ST_DONE;
      done_d    = 1'b1;
      pass_d    = 1'b0;
      timeout_d = 1'b1;
      vpipe_d   = '0;
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      nw_q        <= '0;
      seed_q      <= '0;
      issued_q    <= '0;
      checked_q   <= '0;
      vpipe_q     <= '0;
      tmo_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
      ferr_idx_q  <= '0;
      ferr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      nw_q        <= nw_d;
      seed_q      <= seed_d;
      issued_q    <= issued_d;
      checked_q   <= checked_d;
      vpipe_q     <= vpipe_d;
      tmo_cnt_q   <= tmo_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
      ferr_idx_q  <= ferr_idx_d;
      ferr_data_q <= ferr_data_d;
    end
  end

  assign read_en_o        = rd_en_c;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign timeout_o        = timeout_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_idx_o  = ferr_idx_q;
  assign first_err_data_o = ferr_data_q;

endmodule
